// File: rtl/grid_game_pkg.sv
// rtl/grid_game_pkg.sv - shared FSM encoding, step codes, move directions and repeat timing for the grid game
package grid_game_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ARMED = 2'd2,
        HELD  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_t;

    localparam logic [2:0] STEP_SELECT = 3'b011;

    // 0.5 s first repeat and 0.2 s subsequent repeats at 25 MHz
    localparam int HOLD_CYC = 12_500_000;
    localparam int REP_CYC  = 5_000_000;

endpackage

// File: rtl/grid_step_calc.sv
// rtl/grid_step_calc.sv - combinational (idx, direction) -> next idx on a wrapping ROWS x COLS grid
module grid_step_calc
    import grid_game_pkg::*;
#(
    parameter int ROWS  = 2,
    parameter int COLS  = 2,
    parameter int IDX_W = 3
) (
    input  logic [IDX_W-1:0] idx,
    input  dir_t             dir,
    output logic [IDX_W-1:0] next_idx
);

    int lin;
    int row;
    int col;

    always_comb begin
        lin = int'(idx);
        // out-of-range indices (e.g. a bad target) collapse to square 0
        if (lin >= ROWS * COLS) begin
            lin = 0;
        end
        row = lin / COLS;
        col = lin % COLS;
        case (dir)
            DIR_UP:    row = (row + ROWS - 1) % ROWS;
            DIR_DOWN:  row = (row + 1) % ROWS;
            DIR_LEFT:  col = (col + COLS - 1) % COLS;
            DIR_RIGHT: col = (col + 1) % COLS;
            default:   ;
        endcase
        next_idx = IDX_W'(row * COLS + col);
    end

endmodule

// File: rtl/grid_cursor_ctrl.sv
// rtl/grid_cursor_ctrl.sv - edge-qualified cursor mover for the select-square step; GRID_CURSOR_AUTO_REPEAT_EN adds hold-to-repeat
module grid_cursor_ctrl
    import grid_game_pkg::*;
#(
    parameter int         ROWS    = 2,
    parameter int         COLS    = 2,
    parameter int         IDX_W   = 3,
    parameter logic [2:0] STEP_ID = STEP_SELECT,
    parameter int         CNT_W   = 8
) (
    input  logic             clk25MHz,
    input  logic             reset,
    input  logic [2:0]       step,
    input  logic [IDX_W-1:0] target,
    input  logic             up,
    input  logic             down,
    input  logic             left,
    input  logic             right,
    output logic [IDX_W-1:0] cursor,
    output logic             active,
    output logic             moved,
    output logic [CNT_W-1:0] move_count
);

    // start square sits one column right of the target, or one row down on a single-column grid
    localparam dir_t START_DIR = (COLS == 1) ? DIR_DOWN : DIR_RIGHT;

    state_t           state, state_n;
    logic [IDX_W-1:0] cursor_n;
    logic [CNT_W-1:0] count_n;
    logic             moved_n;
    logic             do_move;
    logic             any_btn;
    logic             in_step;
    dir_t             press_dir;
    logic [IDX_W-1:0] start_idx;
    logic [IDX_W-1:0] step_idx;

    grid_step_calc #(.ROWS(ROWS), .COLS(COLS), .IDX_W(IDX_W)) u_start (
        .idx      (target),
        .dir      (START_DIR),
        .next_idx (start_idx)
    );

    grid_step_calc #(.ROWS(ROWS), .COLS(COLS), .IDX_W(IDX_W)) u_move (
        .idx      (cursor),
        .dir      (press_dir),
        .next_idx (step_idx)
    );

    always_comb begin
        press_dir = DIR_NONE;
        if (up) begin
            press_dir = DIR_UP;
        end else if (down) begin
            press_dir = DIR_DOWN;
        end else if (left) begin
            press_dir = DIR_LEFT;
        end else if (right) begin
            press_dir = DIR_RIGHT;
        end
    end

    assign any_btn = up | down | left | right;
    assign in_step = (step == STEP_ID);
    assign active  = (state == ARMED) || (state == HELD);

`ifdef GRID_CURSOR_AUTO_REPEAT_EN
    localparam int TMR_W = $clog2(HOLD_CYC + 1);

    dir_t             held_dir, held_dir_n;
    logic [TMR_W-1:0] rep_timer, rep_timer_n;
    logic             rep_first, rep_first_n;
    logic             rep_ok, rep_ok_n;
    logic [TMR_W-1:0] rep_limit;

    assign rep_limit = rep_first ? TMR_W'(HOLD_CYC - 1) : TMR_W'(REP_CYC - 1);
`endif

    always_comb begin
        state_n  = state;
        cursor_n = cursor;
        count_n  = move_count;
        moved_n  = 1'b0;
        do_move  = 1'b0;
`ifdef GRID_CURSOR_AUTO_REPEAT_EN
        held_dir_n  = held_dir;
        rep_timer_n = rep_timer;
        rep_first_n = rep_first;
        rep_ok_n    = rep_ok;
`endif
        case (state)
            IDLE: begin
                if (in_step) begin
                    state_n = LOAD;
                end
            end
            LOAD: begin
                if (!in_step) begin
                    state_n = IDLE;
                end else begin
                    cursor_n = start_idx;
                    count_n  = '0;
                    state_n  = any_btn ? HELD : ARMED;
`ifdef GRID_CURSOR_AUTO_REPEAT_EN
                    // a button carried across step entry must never auto-repeat
                    held_dir_n  = press_dir;
                    rep_timer_n = '0;
                    rep_first_n = 1'b1;
                    rep_ok_n    = 1'b0;
`endif
                end
            end
            ARMED: begin
                if (!in_step) begin
                    state_n = IDLE;
                end else if (any_btn) begin
                    do_move = 1'b1;
                    state_n = HELD;
`ifdef GRID_CURSOR_AUTO_REPEAT_EN
                    held_dir_n  = press_dir;
                    rep_timer_n = '0;
                    rep_first_n = 1'b1;
                    rep_ok_n    = 1'b1;
`endif
                end
            end
            HELD: begin
                if (!in_step) begin
                    state_n = IDLE;
                end else if (!any_btn) begin
                    state_n = ARMED;
                end
`ifdef GRID_CURSOR_AUTO_REPEAT_EN
                else if (press_dir != held_dir) begin
                    held_dir_n  = press_dir;
                    rep_timer_n = '0;
                    rep_first_n = 1'b1;
                end else if (rep_ok) begin
                    if (rep_timer == rep_limit) begin
                        do_move     = 1'b1;
                        rep_timer_n = '0;
                        rep_first_n = 1'b0;
                    end else begin
                        rep_timer_n = rep_timer + TMR_W'(1);
                    end
                end
`endif
            end
            default: state_n = IDLE;
        endcase

        if (do_move) begin
            cursor_n = step_idx;
            moved_n  = 1'b1;
            count_n  = (move_count == {CNT_W{1'b1}}) ? move_count : move_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk25MHz) begin
        if (reset) begin
            state      <= IDLE;
            cursor     <= '0;
            move_count <= '0;
            moved      <= 1'b0;
        end else begin
            state      <= state_n;
            cursor     <= cursor_n;
            move_count <= count_n;
            moved      <= moved_n;
        end
    end

`ifdef GRID_CURSOR_AUTO_REPEAT_EN
    always_ff @(posedge clk25MHz) begin
        if (reset) begin
            held_dir  <= DIR_NONE;
            rep_timer <= '0;
            rep_first <= 1'b1;
            rep_ok    <= 1'b0;
        end else begin
            held_dir  <= held_dir_n;
            rep_timer <= rep_timer_n;
            rep_first <= rep_first_n;
            rep_ok    <= rep_ok_n;
        end
    end
`endif

endmodule

// File: tb/tb_grid_cursor_ctrl.sv
// tb/tb_grid_cursor_ctrl.sv - checks a 2x2 and a 3x4 cursor controller against a row/column model
module tb_grid_cursor_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] step = 3'd0;
    logic [2:0] target_a = 3'd0;
    logic [3:0] target_b = 4'd11;
    logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;

    logic [2:0] cur_a;
    logic [3:0] cur_b;
    logic       act_a, act_b, mv_a, mv_b;
    logic [7:0] cnt_a, cnt_b;

    int total = 0;
    int bad = 0;

    always #20 clk = ~clk;

    grid_cursor_ctrl #(.ROWS(2), .COLS(2), .IDX_W(3), .STEP_ID(3'd3), .CNT_W(8)) dut_a (
        .clk25MHz(clk), .reset(reset), .step(step), .target(target_a),
        .up(up), .down(down), .left(left), .right(right),
        .cursor(cur_a), .active(act_a), .moved(mv_a), .move_count(cnt_a)
    );

    grid_cursor_ctrl #(.ROWS(3), .COLS(4), .IDX_W(4), .STEP_ID(3'd3), .CNT_W(8)) dut_b (
        .clk25MHz(clk), .reset(reset), .step(step), .target(target_b),
        .up(up), .down(down), .left(left), .right(right),
        .cursor(cur_b), .active(act_b), .moved(mv_b), .move_count(cnt_b)
    );

    // waiting: entered step, next cycle loads; selecting: cursor live; need_release: presses ignored
    typedef struct {
        bit in_play;
        bit loading;
        bit need_release;
        int cur;
        int cnt;
        bit mv;
    } mdl_t;

    mdl_t ma = '{0, 0, 0, 0, 0, 0};
    mdl_t mb = '{0, 0, 0, 0, 0, 0};

    function automatic mdl_t mdl_next(mdl_t m, int rows, int cols, int tgt);
        mdl_t n;
        int r, c, t;
        bit any;
        n = m;
        n.mv = 0;
        any = up | down | left | right;
        if (reset) begin
            n = '{0, 0, 0, 0, 0, 0};
        end else if (step != 3'd3) begin
            n.in_play = 0;
            n.loading = 0;
        end else if (!m.in_play && !m.loading) begin
            n.loading = 1;
        end else if (m.loading) begin
            t = (tgt >= rows * cols) ? 0 : tgt;
            r = t / cols;
            c = t % cols;
            if (cols == 1) r = (r + 1) % rows;
            else c = (c + 1) % cols;
            n.cur = r * cols + c;
            n.cnt = 0;
            n.loading = 0;
            n.in_play = 1;
            n.need_release = any;
        end else if (m.need_release) begin
            if (!any) n.need_release = 0;
        end else if (any) begin
            r = m.cur / cols;
            c = m.cur % cols;
            if (up) r = (r + rows - 1) % rows;
            else if (down) r = (r + 1) % rows;
            else if (left) c = (c + cols - 1) % cols;
            else c = (c + 1) % cols;
            n.cur = r * cols + c;
            n.mv = 1;
            n.cnt = (m.cnt >= 255) ? 255 : m.cnt + 1;
            n.need_release = 1;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        ma <= mdl_next(ma, 2, 2, int'(target_a));
        mb <= mdl_next(mb, 3, 4, int'(target_b));
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("a_cursor", int'(cur_a), ma.cur);
        check("a_active", int'(act_a), int'(ma.in_play));
        check("a_moved", int'(mv_a), int'(ma.mv));
        check("a_count", int'(cnt_a), ma.cnt);
        check("b_cursor", int'(cur_b), mb.cur);
        check("b_active", int'(act_b), int'(mb.in_play));
        check("b_moved", int'(mv_b), int'(mb.mv));
        check("b_count", int'(cnt_b), mb.cnt);
    end

    task automatic press(input logic u, input logic d, input logic l, input logic r, input int n);
        up = u; down = d; left = l; right = r;
        repeat (n) @(negedge clk);
        up = 0; down = 0; left = 0; right = 0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("lit_reset_cursor", int'(cur_a), 0);
        check("lit_reset_active", int'(act_a), 0);
        check("lit_reset_count", int'(cnt_a), 0);

        reset = 0;
        step = 3'd3;
        repeat (2) @(negedge clk);
        check("lit_start_a", int'(cur_a), 1);
        check("lit_start_active", int'(act_a), 1);
        check("lit_start_count", int'(cnt_a), 0);
        check("lit_start_b", int'(cur_b), 8);

        left = 1;
        @(negedge clk);
        left = 0;
        check("lit_left_moved", int'(mv_a), 1);
        check("lit_left_a", int'(cur_a), 0);
        check("lit_left_b", int'(cur_b), 11);
        check("lit_left_count", int'(cnt_a), 1);
        @(negedge clk);
        check("lit_moved_pulse", int'(mv_a), 0);
        @(negedge clk);

        press(0, 1, 0, 0, 50);
        check("lit_down_held_a", int'(cur_a), 2);
        check("lit_down_held_cnt", int'(cnt_a), 2);
        check("lit_down_held_b", int'(cur_b), 3);

        press(1, 0, 0, 0, 1);
        check("lit_up_a", int'(cur_a), 0);
        check("lit_up_b", int'(cur_b), 11);
        press(1, 0, 0, 0, 1);
        check("lit_up2_b", int'(cur_b), 7);
        press(1, 0, 1, 0, 1);
        check("lit_upleft_b", int'(cur_b), 3);
        check("lit_upleft_a", int'(cur_a), 0);
        check("lit_upleft_cnt", int'(cnt_a), 5);

        right = 1;
        repeat (3) @(negedge clk);
        step = 3'd0;
        @(negedge clk);
        check("lit_leave_active", int'(act_a), 0);
        check("lit_leave_a", int'(cur_a), 1);
        check("lit_leave_b", int'(cur_b), 0);
        check("lit_leave_cnt", int'(cnt_a), 6);
        repeat (3) @(negedge clk);
        step = 3'd3;
        repeat (12) @(negedge clk);
        check("lit_carry_a", int'(cur_a), 1);
        check("lit_carry_b", int'(cur_b), 8);
        check("lit_carry_cnt", int'(cnt_a), 0);
        right = 0;
        repeat (2) @(negedge clk);
        press(0, 1, 0, 0, 1);
        check("lit_after_carry_a", int'(cur_a), 3);
        check("lit_after_carry_b", int'(cur_b), 0);

        for (int i = 0; i < 256; i++) begin
            press(0, 0, 0, 1, 1);
        end
        check("lit_sat_count", int'(cnt_a), 255);
        check("lit_sat_a", int'(cur_a), 3);
        check("lit_sat_b", int'(cur_b), 0);

        up = 1;
        reset = 1;
        @(negedge clk);
        check("lit_rst_press_cursor", int'(cur_a), 0);
        check("lit_rst_press_moved", int'(mv_a), 0);
        check("lit_rst_press_active", int'(act_a), 0);
        check("lit_rst_press_count", int'(cnt_a), 0);
        up = 0;
        target_a = 3'd7;
        target_b = 4'd5;
        reset = 0;
        repeat (2) @(negedge clk);
        check("lit_bad_target_a", int'(cur_a), 1);
        check("lit_target5_b", int'(cur_b), 6);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/grid_cursor_ctrl.md
Name: grid_cursor_ctrl

Overview:
- Parametrised cursor-movement controller for the colour-matching game's "select square" step.
- Generalised from the fixed 2x2 selector to a ROWS x COLS grid:
  - true directional moves with wrap-around
  - one move per button press (edge-qualified)
  - explicit state machine and synchronous reset
  - move counter and move strobe
- Sits between the debounced push-button inputs / game step sequencer and the VGA square renderer, which highlights the square at `cursor`.

Parameters:
- ROWS, 2, grid rows (>=1).
- COLS, 2, grid columns (>=1).
- IDX_W, 3, width of square index; must satisfy 2^IDX_W >= ROWS*COLS.
- STEP_ID, 3, value of `step` during which this block is active.
- CNT_W, 8, width of move counter.

Ports:
- clk25MHz  in  1  pixel/system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- step  in  3  current game step from sequencer.
- target  in  IDX_W  index of the target square for this round (row-major, 0..ROWS*COLS-1).
- up, down, left, right  in  1 each  debounced button levels, active-high.
- cursor  out  IDX_W  currently selected square index (registered).
- active  out  1  high while the FSM is in ARMED or HELD.
- moved  out  1  one-cycle pulse in the cycle `cursor` takes a new value due to a move.
- move_count  out  CNT_W  moves since step entry; saturates at all-ones.

Behaviour:
- Reset: state=IDLE; cursor=0, active=0, moved=0, move_count=0. Reset has priority over every other event in the same cycle.
- Index mapping: row = idx / COLS, col = idx % COLS.
- FSM states: IDLE, LOAD, ARMED, HELD.
- IDLE:
  - active=0; cursor holds its last value.
  - When step==STEP_ID, go to LOAD.
- LOAD (one cycle):
  - cursor <= start square: same row as target, col = (col_t+1) mod COLS.
  - If COLS==1: row = (row_t+1) mod ROWS.
  - If ROWS*COLS==1: start = 0.
  - move_count <= 0.
  - Next state: HELD if any button is high, else ARMED. A button held across step entry never causes a move.
- ARMED:
  - On any button high, apply exactly one move, assert moved for one cycle, increment move_count (saturating), go to HELD.
  - Cursor updates in the cycle after the button is sampled high (1-cycle latency).
- HELD:
  - No moves.
  - Return to ARMED in the cycle after all four buttons are sampled low.
- Move rules:
  - up: row = (row-1) mod ROWS; down: row = (row+1) mod ROWS.
  - left: col = (col-1) mod COLS; right: col = (col+1) mod COLS.
  - Wrap at every edge; a 1-wide dimension leaves that coordinate unchanged, but the press still counts as a move.
- Simultaneous buttons: a single move, priority up > down > left > right.
- Leaving the step: step!=STEP_ID in any non-IDLE state -> IDLE next cycle; no move is applied in that cycle; cursor and move_count hold.
- Re-entering the step always passes through LOAD.
- Index arithmetic uses integers internally; cursor never exceeds ROWS*COLS-1.
- target >= ROWS*COLS: treated as target 0.

Optional Feature:
- Macro: GRID_CURSOR_AUTO_REPEAT_EN.
- Defined:
  - In HELD, if the same highest-priority button stays high for HOLD_CYC = 12,500,000 cycles (0.5 s), apply a repeat move.
  - Then apply a further repeat every REP_CYC = 5,000,000 cycles while it stays held.
  - Each repeat pulses moved and increments move_count.
  - A change of highest-priority button restarts the hold timer without moving.
  - Both constants are localparams.
- Undefined: no timer logic is present; a held button yields exactly one move.

Decomposition:
- Shared package grid_game_pkg holds:
  - state encoding: IDLE=2'd0, LOAD=2'd1, ARMED=2'd2, HELD=2'd3
  - step code constants: STEP_SELECT=3'b011
  - HOLD_CYC and REP_CYC
- One natural sub-module: grid_step_calc, a purely combinational block that maps (idx, direction) -> next idx with wrap. It is reused by the start-square computation and unit-tested alone.

Test Plan:
- Reset, then ROWS=COLS=2, step=3, target=0, no buttons -> cursor=1 two cycles after step rises; active=1; move_count=0.
- From cursor=1, single-cycle `right` pulse -> cursor=0 next cycle, moved=1 for one cycle, move_count=1.
- From cursor=0, `down` held 50 cycles (feature off) -> exactly one move, cursor=2. Release then press `up` -> cursor=0.
- ROWS=3, COLS=4, target=11 -> start=8. `left` -> 11; `up` -> 7. Then `up`+`left` asserted together -> only up applied, cursor=3.
- Button held high while step changes 0->3 -> no move until release-then-press. step drops mid-HELD -> active=0 next cycle, cursor held. reset asserted together with a press -> all outputs 0.
- GRID_CURSOR_AUTO_REPEAT_EN defined, `right` held 12,500,000+5,000,000 cycles -> 3 moves total, move_count=3.
